// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizes and types for the register-file scoreboard, plus the global text macros
// (`WORD, `SB_AW, `SB_CNTW, `SB_ZERO_REG) the parameters default from.
`ifndef REGFILE_SB_DEFS
`define REGFILE_SB_DEFS
`define WORD        [31:0]
`define SB_AW       5
`define SB_CNTW     2
`define SB_ZERO_REG 31
`endif

package regfile_scoreboard_pkg;
   localparam int SB_AW       = `SB_AW;
   localparam int SB_NREGS    = 1 << `SB_AW;
   localparam int SB_CNTW     = `SB_CNTW;
   localparam int SB_ZERO_REG = `SB_ZERO_REG;

   typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

   typedef struct packed {
      logic              valid;
      logic [SB_AW-1:0]  rd;
      logic `WORD        data;
   } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard_wb_rr_arbiter.sv
// Two-way round-robin arbiter for the writeback sources; the last_grant flop only
// moves on a contested cycle, so an uncontested grant never costs the other side a turn.
module wb_rr_arbiter
   import regfile_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_a_valid,
   input  logic i_b_valid,
   output logic o_grant_a,
   output logic o_grant_b
);
   grant_e r_last;

   always_comb begin
      o_grant_a = i_a_valid & (!i_b_valid | (r_last == GRANT_B));
      o_grant_b = i_b_valid & (!i_a_valid | (r_last == GRANT_A));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_last <= GRANT_B;
      else if (i_a_valid & i_b_valid)
         r_last <= o_grant_a ? GRANT_A : GRANT_B;
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters, issue hazard stall and
// writeback port arbitration. Optional REGFILE_SB_STATS_EN adds a saturating stall counter.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int NREGS    = SB_NREGS,
   parameter int AW       = SB_AW,
   parameter int CNTW     = SB_CNTW,
   parameter int ZERO_REG = SB_ZERO_REG
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          issue_valid,
   output logic          issue_ready,
   input  logic [AW-1:0] issue_rs1,
   input  logic [AW-1:0] issue_rs2,
   input  logic          issue_use_rs2,
   input  logic [AW-1:0] issue_rd,
   input  logic          issue_rd_en,
   input  logic          wba_valid,
   input  logic [AW-1:0] wba_rd,
   input  logic `WORD    wba_data,
   output logic          wba_ready,
   input  logic          wbb_valid,
   input  logic [AW-1:0] wbb_rd,
   input  logic `WORD    wbb_data,
   output logic          wbb_ready,
   output logic          RegWrite,
   output logic [AW-1:0] write_register,
   output logic `WORD    write_data,
   output logic          sb_err
`ifdef REGFILE_SB_STATS_EN
   ,
   output logic [31:0]   stall_cycles
`endif
);
   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [AW-1:0]   ZR      = AW'(ZERO_REG);

   logic [NREGS-1:0][CNTW-1:0] r_cnt;
   logic                       r_sb_err;
   logic                       w_gnt_a, w_gnt_b, w_fire, w_orphan;
   logic [NREGS-1:0]           w_inc, w_dec;
   wb_req_t                    w_wb;

   // Registered counts only: a register being written this cycle still reads as busy.
   always_comb begin
      issue_ready = (r_cnt[issue_rs1] == '0)
                  & !(issue_use_rs2 & (r_cnt[issue_rs2] != '0))
                  & !(issue_rd_en & (issue_rd != ZR) & (r_cnt[issue_rd] == CNT_MAX));
   end

   wb_rr_arbiter u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_a_valid (wba_valid),
      .i_b_valid (wbb_valid),
      .o_grant_a (w_gnt_a),
      .o_grant_b (w_gnt_b)
   );

   always_comb begin
      w_wb = '0;
      if (w_gnt_a)      w_wb = '{valid: 1'b1, rd: wba_rd, data: wba_data};
      else if (w_gnt_b) w_wb = '{valid: 1'b1, rd: wbb_rd, data: wbb_data};
   end

   assign wba_ready      = w_gnt_a;
   assign wbb_ready      = w_gnt_b;
   assign RegWrite       = w_wb.valid & (w_wb.rd != ZR);
   assign write_register = w_wb.rd;
   assign write_data     = w_wb.data;

   assign w_fire   = issue_valid & issue_ready;
   assign w_orphan = RegWrite & (r_cnt[w_wb.rd] == '0);

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         w_inc[i] = w_fire & issue_rd_en & (issue_rd != ZR) & (issue_rd == AW'(i));
         w_dec[i] = RegWrite & (w_wb.rd == AW'(i)) & (r_cnt[i] != '0);
      end
   end

   // Simultaneous increment and decrement on one register cancel out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_sb_err <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_inc[i] & !w_dec[i])
               r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_dec[i] & !w_inc[i])
               r_cnt[i] <= r_cnt[i] - 1'b1;
         end
         if (w_orphan)
            r_sb_err <= 1'b1;
      end
   end

   assign sb_err = r_sb_err;

`ifdef REGFILE_SB_STATS_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_stall_cycles <= '0;
      else if (issue_valid & !issue_ready & (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected regfile writes are queued by the
// stimulus and popped by a negedge monitor; handshake/flag checks are made inline.
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        issue_valid, issue_ready, issue_use_rs2, issue_rd_en;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        wba_valid, wba_ready, wbb_valid, wbb_ready;
   logic [4:0]  wba_rd, wbb_rd;
   logic [31:0] wba_data, wbb_data;
   logic        RegWrite, sb_err;
   logic [4:0]  write_register;
   logic [31:0] write_data;
`ifdef REGFILE_SB_STATS_EN
   logic [31:0] stall_cycles;
`endif

   regfile_scoreboard dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_rs1      (issue_rs1),
      .issue_rs2      (issue_rs2),
      .issue_use_rs2  (issue_use_rs2),
      .issue_rd       (issue_rd),
      .issue_rd_en    (issue_rd_en),
      .wba_valid      (wba_valid),
      .wba_rd         (wba_rd),
      .wba_data       (wba_data),
      .wba_ready      (wba_ready),
      .wbb_valid      (wbb_valid),
      .wbb_rd         (wbb_rd),
      .wbb_data       (wbb_data),
      .wbb_ready      (wbb_ready),
      .RegWrite       (RegWrite),
      .write_register (write_register),
      .write_data     (write_data),
      .sb_err         (sb_err)
`ifdef REGFILE_SB_STATS_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_rd_en = 0; issue_use_rs2 = 0;
      issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
      wba_valid = 0; wba_rd = 0; wba_data = 0;
      wbb_valid = 0; wbb_rd = 0; wbb_data = 0;
   endtask

   task automatic do_issue(input logic [4:0] rs1, input logic [4:0] rd, input logic rd_en);
      issue_valid = 1; issue_rs1 = rs1; issue_rd = rd; issue_rd_en = rd_en;
      issue_use_rs2 = 0; issue_rs2 = 0;
   endtask

   // Monitor: every regfile write must match the oldest queued expectation.
   always @(negedge clk) begin
      wr_t e;
      if (reset_n && RegWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got rd=%0d data=%0h, none expected", write_register, write_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_rd", {27'd0, write_register}, {27'd0, e.rd});
            chk("wr_data", write_data, e.data);
         end
      end
   end

   initial begin
      idle();
      reset_n = 0;
      step();
      @(negedge clk);
      chk("rst_regwrite", {31'd0, RegWrite}, 0);
      chk("rst_sb_err", {31'd0, sb_err}, 0);
      chk("rst_wba_ready", {31'd0, wba_ready}, 0);
      chk("rst_wbb_ready", {31'd0, wbb_ready}, 0);
      chk("rst_wreg", {27'd0, write_register}, 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_issue_ready", {31'd0, issue_ready}, 1);
      step();
      reset_n = 1;

      // 1: RAW stall on rd=3 until its writeback edge
      do_issue(0, 3, 1);
      @(negedge clk); chk("t1_issue_rd3", {31'd0, issue_ready}, 1);
      step();
      do_issue(3, 0, 0);
      @(negedge clk); chk("t1_raw_rs1", {31'd0, issue_ready}, 0);
      step();
      issue_rs1 = 0; issue_rs2 = 3; issue_use_rs2 = 1;
      @(negedge clk); chk("t1_raw_rs2", {31'd0, issue_ready}, 0);
      issue_use_rs2 = 0;
      #1; chk("t1_rs2_unused", {31'd0, issue_ready}, 1);
      step();
      issue_rs1 = 3; issue_rs2 = 0;
      wba_valid = 1; wba_rd = 3; wba_data = 32'h3333; push(3, 32'h3333);
      @(negedge clk);
      chk("t1_stall_at_wb", {31'd0, issue_ready}, 0);
      chk("t1_wba_ready", {31'd0, wba_ready}, 1);
      step();
      wba_valid = 0;
      @(negedge clk); chk("t1_ready_after_wb", {31'd0, issue_ready}, 1);
      step();
      idle();

      // 2: round-robin alternation
      for (int k = 0; k < 4; k++) begin
         do_issue(0, (k < 2) ? 5'd5 : 5'd7, 1);
         step();
      end
      idle();
      wba_valid = 1; wba_rd = 5; wba_data = 32'hA1;
      wbb_valid = 1; wbb_rd = 7; wbb_data = 32'hB1;
      push(5, 32'hA1);
      @(negedge clk);
      chk("t2_c1_a", {31'd0, wba_ready}, 1);
      chk("t2_c1_b", {31'd0, wbb_ready}, 0);
      step();
      wba_valid = 0; push(7, 32'hB1);
      @(negedge clk); chk("t2_b_next", {31'd0, wbb_ready}, 1);
      step();
      wba_valid = 1; wba_data = 32'hA2; wbb_data = 32'hB2; push(7, 32'hB2);
      @(negedge clk);
      chk("t2_c2_b", {31'd0, wbb_ready}, 1);
      chk("t2_c2_a", {31'd0, wba_ready}, 0);
      step();
      wbb_valid = 0; push(5, 32'hA2);
      @(negedge clk); chk("t2_a_next", {31'd0, wba_ready}, 1);
      step();
      idle();

      // 3: WAW saturation on rd=4
      for (int k = 0; k < 3; k++) begin
         do_issue(0, 4, 1);
         @(negedge clk); chk("t3_issue_rd4", {31'd0, issue_ready}, 1);
         step();
      end
      @(negedge clk); chk("t3_waw_stall", {31'd0, issue_ready}, 0);
      step();
      wba_valid = 1; wba_rd = 4; wba_data = 32'h41; push(4, 32'h41);
      @(negedge clk); chk("t3_stall_at_wb", {31'd0, issue_ready}, 0);
      step();
      wba_valid = 0;
      @(negedge clk); chk("t3_ready_after_wb", {31'd0, issue_ready}, 1);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         wba_valid = 1; wba_rd = 4; wba_data = 32'h42 + k; push(4, 32'h42 + k);
         step();
      end
      idle();
      do_issue(4, 0, 0);
      @(negedge clk); chk("t3_drained", {31'd0, issue_ready}, 1);
      step();
      idle();

      // 4: simultaneous inc/dec on rd=6
      do_issue(0, 6, 1);
      step();
      do_issue(0, 6, 1);
      wbb_valid = 1; wbb_rd = 6; wbb_data = 32'h66; push(6, 32'h66);
      @(negedge clk);
      chk("t4_issue_ready", {31'd0, issue_ready}, 1);
      chk("t4_wbb_ready", {31'd0, wbb_ready}, 1);
      step();
      idle();
      do_issue(6, 0, 0);
      @(negedge clk); chk("t4_still_stall", {31'd0, issue_ready}, 0);
      wbb_valid = 1; wbb_rd = 6; wbb_data = 32'h67; push(6, 32'h67);
      step();
      wbb_valid = 0;
      @(negedge clk); chk("t4_ready_after_wb", {31'd0, issue_ready}, 1);
      step();
      idle();

      // 5: zero register is never tracked and never written
      do_issue(31, 31, 1);
      wba_valid = 1; wba_rd = 31; wba_data = 32'hDEAD;
      @(negedge clk);
      chk("t5_regwrite", {31'd0, RegWrite}, 0);
      chk("t5_wba_ready", {31'd0, wba_ready}, 1);
      chk("t5_issue_ready", {31'd0, issue_ready}, 1);
      step();
      idle();
      do_issue(31, 0, 0);
      @(negedge clk);
      chk("t5_xzr_no_stall", {31'd0, issue_ready}, 1);
      chk("t5_sb_err_clear", {31'd0, sb_err}, 0);
      step();
      idle();

      // 6: orphan writeback sets sticky sb_err
      wba_valid = 1; wba_rd = 9; wba_data = 32'h99; push(9, 32'h99);
      @(negedge clk);
      chk("t6_regwrite", {31'd0, RegWrite}, 1);
      chk("t6_err_before", {31'd0, sb_err}, 0);
      step();
      idle();
      @(negedge clk); chk("t6_err_set", {31'd0, sb_err}, 1);
      repeat (3) step();
      @(negedge clk); chk("t6_err_sticky", {31'd0, sb_err}, 1);
      step();

      // reset mid-operation drops pending counts and the error flag
      do_issue(0, 12, 1);
      step();
      idle();
      reset_n = 0;
      @(negedge clk);
      chk("rst2_sb_err", {31'd0, sb_err}, 0);
      step();
      reset_n = 1;
      do_issue(12, 0, 0);
      @(negedge clk); chk("rst2_cnt_cleared", {31'd0, issue_ready}, 1);
      step();
      idle();

`ifdef REGFILE_SB_STATS_EN
      do_issue(0, 10, 1);
      step();
      do_issue(10, 0, 0);
      repeat (5) step();
      idle();
      @(negedge clk); chk("stats_stall_cycles", stall_cycles, 5);
      step();
      wba_valid = 1; wba_rd = 10; wba_data = 32'h10; push(10, 32'h10);
      step();
      idle();
`endif

      repeat (2) step();
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
